seg_marquee: RTL and testbench

//  Parametrised scrolling marquee for NUM_DIGITS active-low 7-segment digits.

---
 rtl/seg_marquee_pkg.sv | 29 ++
 rtl/seg_marquee_if.sv | 26 ++
 rtl/seg_marquee_hex_to_seg7.sv | 35 +++
 rtl/seg_marquee.sv | 102 ++++++++++
 tb/tb_seg_marquee.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/seg_marquee_pkg.sv
// Shared constants for the scrolling 7-segment marquee: active-low gfedcba digit patterns
// and the scroll-direction type. Used by hex_to_seg7 and seg_marquee (see SEG_MARQUEE_HEX_EN).
package seg_marquee_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_REV = 1'b1
    } dir_e;

endpackage

// File: rtl/seg_marquee_if.sv
// Control/display bundle between board-level control and the marquee.
// The master drives control and message; the slave (seg_marquee) drives the display side.
interface seg_marquee_if #(
    parameter int NUM_DIGITS = 3,
    parameter int MSG_LEN    = 3
);
    localparam int FRAME_W = $clog2(MSG_LEN + NUM_DIGITS);

    logic                    en;
    logic                    dir;
    logic                    msg_load;
    logic [MSG_LEN*4-1:0]    msg;
    logic [NUM_DIGITS*7-1:0] seg;
    logic [FRAME_W-1:0]      frame;
    logic                    wrap;

    modport master (
        output en, dir, msg_load, msg,
        input  seg, frame, wrap
    );

    modport slave (
        input  en, dir, msg_load, msg,
        output seg, frame, wrap
    );
endinterface

// File: rtl/seg_marquee_hex_to_seg7.sv
// hex_to_seg7: combinational nibble -> active-low gfedcba decoder.
// With SEG_MARQUEE_HEX_EN defined, 10-15 show A,b,C,d,E,F; otherwise they show a dash.
module hex_to_seg7
    import seg_marquee_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        o_seg = SEG_DASH;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
`ifdef SEG_MARQUEE_HEX_EN
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            4'hF: o_seg = SEG_F;
`else
            default: o_seg = SEG_DASH;
`endif
        endcase
    end
endmodule

// File: rtl/seg_marquee.sv
// seg_marquee: scrolls a latched hex message across NUM_DIGITS 7-segment digits at a prescaled rate.
// Hex letters A-F are shown only when SEG_MARQUEE_HEX_EN is defined (see hex_to_seg7).
module seg_marquee
    import seg_marquee_pkg::*;
#(
    parameter int                   NUM_DIGITS = 3,
    parameter int                   MSG_LEN    = 3,
    parameter int                   TICK_DIV   = 25_000_000,
    parameter logic [3:0]           FILL       = 4'h0,
    parameter logic [MSG_LEN*4-1:0] MSG_RESET  = 'h321
) (
    input  logic          clk,
    input  logic          rst,
    seg_marquee_if.slave  bus
);
    localparam int F       = MSG_LEN + NUM_DIGITS;
    localparam int FRAME_W = $clog2(F);
    localparam int CNT_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(F - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0]        r_cnt, w_cnt_nxt;
    logic [FRAME_W-1:0]      r_frame, w_frame_nxt;
    logic [MSG_LEN*4-1:0]    r_msg;
    logic                    r_wrap, w_wrap_nxt;
    logic [NUM_DIGITS*7-1:0] r_seg, w_seg_nxt;
    logic [NUM_DIGITS*4-1:0] w_nibs;
    logic [6:0]              w_fill_seg;
    logic                    w_step;
    dir_e                    w_dir;

    assign w_step = bus.en && (r_cnt == CNT_LAST);
    assign w_dir  = dir_e'(bus.dir);

    // msg_load outranks a coincident step; dir only matters at a step.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_frame_nxt = r_frame;
        w_wrap_nxt  = 1'b0;
        if (bus.msg_load) begin
            w_cnt_nxt   = '0;
            w_frame_nxt = '0;
        end else if (bus.en) begin
            w_cnt_nxt = w_step ? '0 : r_cnt + CNT_W'(1);
            if (w_step) begin
                if (w_dir == DIR_FWD) begin
                    w_wrap_nxt  = (r_frame == FRAME_LAST);
                    w_frame_nxt = w_wrap_nxt ? '0 : r_frame + FRAME_W'(1);
                end else begin
                    w_wrap_nxt  = (r_frame == '0);
                    w_frame_nxt = w_wrap_nxt ? FRAME_LAST : r_frame - FRAME_W'(1);
                end
            end
        end
    end

    // Digit i shows message digit j = frame-1-i; computed from the next frame so seg tracks frame.
    always_comb begin
        int j;
        w_nibs = {NUM_DIGITS{FILL}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            j = int'(w_frame_nxt) - 1 - i;
            if (j >= 0 && j < MSG_LEN)
                w_nibs[4*i +: 4] = r_msg[4*(MSG_LEN-1-j) +: 4];
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex_to_seg7 u_dec (
            .i_nib (w_nibs[4*g +: 4]),
            .o_seg (w_seg_nxt[7*g +: 7])
        );
    end

    hex_to_seg7 u_fill_dec (
        .i_nib (FILL),
        .o_seg (w_fill_seg)
    );

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_cnt   <= '0;
            r_frame <= '0;
            r_msg   <= MSG_RESET;
            r_wrap  <= 1'b0;
            r_seg   <= {NUM_DIGITS{w_fill_seg}};
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_frame <= w_frame_nxt;
            r_wrap  <= w_wrap_nxt;
            r_seg   <= w_seg_nxt;
            if (bus.msg_load)
                r_msg <= bus.msg;
        end
    end

    assign bus.seg   = r_seg;
    assign bus.frame = r_frame;
    assign bus.wrap  = r_wrap;
endmodule

// File: tb/tb_seg_marquee.sv
// Directed bench for seg_marquee: a 3-digit/TICK_DIV=4 instance and a 4-digit/MSG_LEN=2/TICK_DIV=1 instance.
// Honours SEG_MARQUEE_HEX_EN when predicting the digit for nibble A.
module tb_seg_marquee;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    seg_marquee_if #(.NUM_DIGITS(3), .MSG_LEN(3)) if1 ();
    seg_marquee_if #(.NUM_DIGITS(4), .MSG_LEN(2)) if2 ();

    seg_marquee #(.NUM_DIGITS(3), .MSG_LEN(3), .TICK_DIV(4), .FILL(4'h0), .MSG_RESET(12'h321)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    seg_marquee #(.NUM_DIGITS(4), .MSG_LEN(2), .TICK_DIV(1), .FILL(4'h0), .MSG_RESET(8'h57)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2.slave)
    );

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h3: return 7'b0110000;
            4'h5: return 7'b0010010;
            4'h7: return 7'b1111000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h9: return 7'b0010000;
`ifdef SEG_MARQUEE_HEX_EN
            4'hA: return 7'b0001000;
`else
            4'hA: return 7'b0111111;
`endif
            default: return 7'b1111111;
        endcase
    endfunction

    // Rightmost digit is the lowest nibble of the hand-written frame.
    function automatic logic [27:0] exp_seg(input logic [15:0] nibs);
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = dec(nibs[4*i +: 4]);
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check1(input string tag, input int fr, input logic [11:0] nibs, input logic wr);
        logic [27:0] e;
        e = exp_seg({4'h0, nibs});
        check({tag, ".frame"}, 64'(if1.frame), 64'(fr));
        check({tag, ".seg"},   64'(if1.seg),   64'(e[20:0]));
        check({tag, ".wrap"},  64'(if1.wrap),  64'(wr));
    endtask

    localparam logic [11:0] FWD [6] = '{12'h003, 12'h032, 12'h321, 12'h210, 12'h100, 12'h000};
    localparam logic [11:0] REV [6] = '{12'h100, 12'h210, 12'h321, 12'h032, 12'h003, 12'h000};
    localparam int          REV_FR [6] = '{5, 4, 3, 2, 1, 0};
    localparam logic [15:0] SEQ2 [6] = '{16'h0005, 16'h0057, 16'h0570, 16'h5700, 16'h7000, 16'h0000};

    initial begin
        logic [27:0] e2;
        if1.en = 1'b1; if1.dir = 1'b0; if1.msg_load = 1'b0; if1.msg = 12'h000;
        if2.en = 1'b1; if2.dir = 1'b0; if2.msg_load = 1'b0; if2.msg = 8'h00;
        rst = 1'b1;
        tick(1);
        check1("reset", 0, 12'h000, 1'b0);
        rst = 1'b0;

        // 1. forward scroll through one full cycle
        for (int k = 0; k < 6; k++) begin
            tick(3);
            check("fwd.hold", 64'(if1.frame), 64'(k));
            tick(1);
            check1($sformatf("fwd%0d", k + 1), (k + 1) % 6, FWD[k], k == 5);
        end
        tick(1);
        check("fwd.wrap_1cyc", 64'(if1.wrap), 64'(0));

        // 2. reverse scroll from frame 0 (one cycle already spent)
        if1.dir = 1'b1;
        tick(3);
        check1("rev1", 5, 12'h100, 1'b1);
        for (int k = 1; k < 6; k++) begin
            tick(4);
            check1($sformatf("rev%0d", k + 1), REV_FR[k], REV[k], 1'b0);
        end
        if1.dir = 1'b0;

        // 3. msg_load coincident with a step at frame 3
        tick(12);
        check1("pre_load", 3, 12'h321, 1'b0);
        tick(3);
        if1.msg_load = 1'b1; if1.msg = 12'h9A5;
        tick(1);
        if1.msg_load = 1'b0;
        check1("load", 0, 12'h000, 1'b0);
        tick(3);
        check("load.presc_hold", 64'(if1.frame), 64'(0));
        tick(1);
        check1("load.f1", 1, 12'h009, 1'b0);
        tick(4);
        check1("load.f2", 2, 12'h09A, 1'b0);
        tick(4);
        check1("load.f3", 3, 12'h9A5, 1'b0);

        // 4. enable hold at frame 2 with prescaler part-way
        if1.msg_load = 1'b1; if1.msg = 12'h321;
        tick(1);
        if1.msg_load = 1'b0;
        tick(9);
        if1.en = 1'b0;
        tick(10);
        check1("hold", 2, 12'h032, 1'b0);
        if1.en = 1'b1;
        tick(2);
        check("hold.remaining", 64'(if1.frame), 64'(2));
        tick(1);
        check1("hold.resume", 3, 12'h321, 1'b0);

        // 5. reset mid-scroll outranks a simultaneous msg_load
        tick(4);
        check1("pre_rst", 4, 12'h210, 1'b0);
        tick(2);
        rst = 1'b1; if1.msg_load = 1'b1; if1.msg = 12'h9A5;
        tick(1);
        rst = 1'b0; if1.msg_load = 1'b0;
        check1("rst", 0, 12'h000, 1'b0);
        tick(12);
        check1("rst.msg", 3, 12'h321, 1'b0);

        // 6. four digits, two-digit message, step every cycle
        if2.msg_load = 1'b1; if2.msg = 8'h57;
        tick(1);
        if2.msg_load = 1'b0;
        check("d2.load.frame", 64'(if2.frame), 64'(0));
        check("d2.load.seg",   64'(if2.seg),   64'(exp_seg(16'h0000)));
        for (int k = 0; k < 6; k++) begin
            tick(1);
            e2 = exp_seg(SEQ2[k]);
            check($sformatf("d2.f%0d.frame", k + 1), 64'(if2.frame), 64'((k + 1) % 6));
            check($sformatf("d2.f%0d.seg", k + 1),   64'(if2.seg),   64'(e2));
            check($sformatf("d2.f%0d.wrap", k + 1),  64'(if2.wrap),  64'(k == 5));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
